// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, clear, and multi-bit logical,
// arithmetic and rotate shifts executed one bit per clock by a small FSM.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_NOP  = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SLL  = 3'b010;
    localparam logic [2:0] M_SRL  = 3'b011;
    localparam logic [2:0] M_SRA  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ROR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       mode_r;
    logic [2:0]       mode_nxt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             is_shift;
    logic             multi_step;

    // One-bit step: returns {bit shifted out, new register value}
    function automatic logic [WIDTH:0] step(input logic [2:0] m,
                                            input logic [WIDTH-1:0] v,
                                            input logic s);
        case (m)
            M_SLL:   step = {v[WIDTH-1], v[WIDTH-2:0], s};
            M_SRL:   step = {v[0], s, v[WIDTH-1:1]};
            M_SRA:   step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            M_ROL:   step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   step = {v[0], v[0], v[WIDTH-1:1]};
            default: step = {1'b0, v};
        endcase
    endfunction

    assign is_shift   = (mode != M_NOP) && (mode != M_LOAD) && (mode != M_CLR);
    assign multi_step = is_shift && (amount > CNT_W'(1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= M_NOP;
            rem    <= '0;
            q      <= '0;
            sout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_r <= mode_nxt;
            rem    <= rem_nxt;
            q      <= q_nxt;
            sout   <= sout_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && multi_step) state_nxt = SHIFT;
            SHIFT:   if (rem == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and status next values; the first shift step runs on the accepting edge
    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        busy_nxt = busy;
        done_nxt = 1'b0;
        rem_nxt  = rem;
        mode_nxt = mode_r;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_nxt = mode;
                    busy_nxt = multi_step;
                    done_nxt = !multi_step;
                    case (mode)
                        M_LOAD: q_nxt = d;
                        M_CLR:  q_nxt = '0;
                        M_NOP:  q_nxt = q;
                        default: begin
                            if (amount != '0) begin
                                {sout_nxt, q_nxt} = step(mode, q, sin);
                                rem_nxt = amount - CNT_W'(1);
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                {sout_nxt, q_nxt} = step(mode_r, q, sin);
                rem_nxt = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized
// commands checked against a whole-command arithmetic reference model.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] d;
    logic       sin;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
        .d(d), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Whole-command result {sout, q} computed arithmetically; sin held constant
    function automatic logic [8:0] model(input logic [2:0] m, input int a,
                                         input logic [7:0] dd, input logic s,
                                         input logic [7:0] qq, input logic so);
        logic [7:0] r;
        logic       o;
        int         k;
        r = qq;
        o = so;
        k = a % 8;
        case (m)
            3'd1: r = dd;
            3'd7: r = 8'h00;
            3'd2: if (a > 0) begin
                r = (a >= 8) ? {8{s}} : ((qq << a) | (s ? 8'((1 << a) - 1) : 8'h00));
                o = (a <= 8) ? qq[8 - a] : s;
            end
            3'd3: if (a > 0) begin
                r = (a >= 8) ? {8{s}} : ((qq >> a) | (s ? ~(8'hFF >> a) : 8'h00));
                o = (a <= 8) ? qq[a - 1] : s;
            end
            3'd4: if (a > 0) begin
                r = 8'($signed(qq) >>> a);
                o = (a <= 8) ? qq[a - 1] : qq[7];
            end
            3'd5: if (a > 0) begin
                r = 8'((qq << k) | (qq >> (8 - k)));
                o = r[0];
            end
            3'd6: if (a > 0) begin
                r = 8'((qq >> k) | (qq << (8 - k)));
                o = r[7];
            end
            default: ;
        endcase
        return {o, r};
    endfunction

    // Issue one command and return at the negedge where done is seen
    task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] dd,
                           input logic s, output int busy_n, output bit got_done);
        @(negedge clk);
        start = 1'b1; mode = m; amount = a; d = dd; sin = s;
        @(negedge clk);
        start = 1'b0; mode = 3'($urandom); amount = 4'($urandom); d = 8'($urandom);
        busy_n = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (busy) busy_n++;
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic load(input logic [7:0] v);
        int  bn;
        bit  gd;
        run_cmd(3'b001, 4'd0, v, 1'b0, bn, gd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1; mode = 3'($urandom); amount = 4'($urandom);
            d = 8'($urandom); sin = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({q, sout, busy, done} !== 11'b0) begin
            failures++;
            $display("FAIL reset_state: q=%h sout=%b busy=%b done=%b, want all zero", q, sout, busy, done);
        end
        start = 1'b0; rst = 1'b0;
        load(8'h96);
        // Abort SLL 5 after two steps
        @(negedge clk);
        start = 1'b1; mode = 3'b010; amount = 4'd5; sin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        begin
            bit saw = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) saw = 1'b1;
            end
            checks++;
            if (saw) begin
                failures++;
                $display("FAIL reset_abort_no_done: done/busy seen after abort, want none");
            end
        end
    endtask

    task automatic test_load_clr();
        int bn;
        bit gd;
        run_cmd(3'b001, 4'd7, 8'hA5, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'hA5 || bn !== 0) begin
            failures++;
            $display("FAIL load: done=%b q=%h busy_cycles=%0d, want done q=a5 busy_cycles=0", gd, q, bn);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL load_done_pulse: done=%b one cycle later, want 0", done);
        end
        run_cmd(3'b111, 4'd3, 8'hFF, 1'b1, bn, gd);
        checks++;
        if (!gd || q !== 8'h00 || bn !== 0) begin
            failures++;
            $display("FAIL clr: done=%b q=%h busy_cycles=%0d, want done q=00 busy_cycles=0", gd, q, bn);
        end
    endtask

    task automatic test_shifts();
        int bn;
        bit gd;
        load(8'h96);
        run_cmd(3'b010, 4'd3, 8'h00, 1'b1, bn, gd);
        checks++;
        if (!gd || q !== 8'hB7 || sout !== 1'b0 || bn !== 2) begin
            failures++;
            $display("FAIL sll3: done=%b q=%h sout=%b busy_cycles=%0d, want q=b7 sout=0 busy_cycles=2", gd, q, sout, bn);
        end
        load(8'h96);
        run_cmd(3'b100, 4'd2, 8'h00, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'hE5 || sout !== 1'b1) begin
            failures++;
            $display("FAIL sra2: done=%b q=%h sout=%b, want q=e5 sout=1", gd, q, sout);
        end
        load(8'h96);
        run_cmd(3'b011, 4'd2, 8'h00, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'h25 || sout !== 1'b1) begin
            failures++;
            $display("FAIL srl2: done=%b q=%h sout=%b, want q=25 sout=1", gd, q, sout);
        end
    endtask

    task automatic test_rotates();
        int bn;
        bit gd;
        load(8'h81);
        run_cmd(3'b101, 4'd1, 8'h00, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'h03 || sout !== 1'b1 || bn !== 0) begin
            failures++;
            $display("FAIL rol1: done=%b q=%h sout=%b busy_cycles=%0d, want q=03 sout=1 busy_cycles=0", gd, q, sout, bn);
        end
        load(8'h81);
        run_cmd(3'b110, 4'd9, 8'h00, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'hC0 || sout !== 1'b1 || bn !== 8) begin
            failures++;
            $display("FAIL ror9: done=%b q=%h sout=%b busy_cycles=%0d, want q=c0 sout=1 busy_cycles=8", gd, q, sout, bn);
        end
        run_cmd(3'b101, 4'd0, 8'h00, 1'b1, bn, gd);
        checks++;
        if (!gd || q !== 8'hC0 || sout !== 1'b1 || bn !== 0) begin
            failures++;
            $display("FAIL amount0: done=%b q=%h sout=%b busy_cycles=%0d, want q=c0 sout=1 busy_cycles=0", gd, q, sout, bn);
        end
    endtask

    task automatic test_back_to_back();
        bit gd;
        logic [8:0] exp;
        load(8'h5A);
        exp = model(3'b010, 4, 8'h00, 1'b1, 8'h5A, sout);
        @(negedge clk);
        start = 1'b1; mode = 3'b010; amount = 4'd4; sin = 1'b1;
        @(negedge clk);
        mode = 3'b001; d = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 20 && !gd; i++) begin
            if (done) gd = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!gd || {sout, q} !== exp) begin
            failures++;
            $display("FAIL ignore_start: done=%b sout,q=%h, want %h", gd, {sout, q}, exp);
        end
        start = 1'b1; mode = 3'b001; d = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (q !== 8'h3C || done !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back: q=%h done=%b, want q=3c done=1", q, done);
        end
    endtask

    task automatic test_saturation();
        int bn;
        bit gd;
        load(8'h80);
        run_cmd(3'b100, 4'd15, 8'h00, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'hFF || sout !== 1'b1) begin
            failures++;
            $display("FAIL sra15: done=%b q=%h sout=%b, want q=ff sout=1", gd, q, sout);
        end
        load(8'h80);
        run_cmd(3'b011, 4'd15, 8'h00, 1'b0, bn, gd);
        checks++;
        if (!gd || q !== 8'h00 || bn !== 14) begin
            failures++;
            $display("FAIL srl15: done=%b q=%h busy_cycles=%0d, want q=00 busy_cycles=14", gd, q, bn);
        end
    endtask

    task automatic test_random();
        int          bn;
        bit          gd;
        logic [7:0]  exp_q;
        logic        exp_sout;
        logic [8:0]  res;
        logic [2:0]  m;
        logic [3:0]  a;
        logic [7:0]  dd;
        logic        s;
        int          exp_busy;
        int          bad;
        load(8'h00);
        run_cmd(3'b011, 4'd1, 8'h00, 1'b0, bn, gd);
        exp_q = 8'h00;
        exp_sout = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            m = 3'($urandom); a = 4'($urandom); dd = 8'($urandom); s = 1'($urandom);
            res = model(m, int'(a), dd, s, exp_q, exp_sout);
            exp_busy = (m >= 3'd2 && m <= 3'd6 && a > 4'd1) ? int'(a) - 1 : 0;
            run_cmd(m, a, dd, s, bn, gd);
            checks++;
            if (!gd || q !== res[7:0] || sout !== res[8] || bn !== exp_busy) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d] mode=%0d amt=%0d: done=%b q=%h sout=%b busy=%0d, want q=%h sout=%b busy=%0d",
                             i, m, a, gd, q, sout, bn, res[7:0], res[8], exp_busy);
            end
            {exp_sout, exp_q} = res;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 3'b000; amount = 4'd0; d = 8'h00; sin = 1'b0;
        test_reset();
        test_load_clr();
        test_shifts();
        test_rotates();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
